// File: rtl/prog_seq_pkg.sv
// Shared types for the batch run controller: FSM states, default counter
// width and the per-program result record.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        REPORT,
        DONE
    } seq_state_t;

    localparam int CNT_W_DEF = 16;
    localparam int IDX_W_DEF = 8;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] idx;
        logic [CNT_W_DEF-1:0] count;
        logic                 timedOut;
    } result_t;

    // Index width for a program count, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating up-counter with synchronous clear; expired flags count == limit.
module cycle_timer
    import prog_seq_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         expired
);

    assign expired = (count == limit);

    // Holding at the limit keeps the counter from ever wrapping.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Batch run controller: starts each program on the processor, times its run
// until halt or timeout, and reports one result record per program.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int  NUM_PROGS   = 3,
    parameter int  CNT_W       = CNT_W_DEF,
    parameter int  START_CYC   = 2,
    parameter int  TIMEOUT_CYC = 16'hFFFF,
    localparam int SEL_W       = idxWidth(NUM_PROGS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             Abort,
    input  logic             ProcAck,
    output logic             ProcStart,
    output logic [SEL_W-1:0] ProgSel,
    output logic             Busy,
    output logic             ResultValid,
    output logic [SEL_W-1:0] ResultIdx,
    output logic [CNT_W-1:0] CycleCount,
    output logic             TimedOut,
    output logic             BatchDone
);

    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_CYC - 1);

    seq_state_t       stateReg;
    seq_state_t       stateNext;
    logic [SEL_W-1:0] progSelNext;
    logic [CNT_W-1:0] runCount;
    logic [CNT_W-1:0] startCountUnused;
    logic             runExpired;
    logic             startExpired;

    // Both timers are held clear outside their own state, so each entry starts at 0.
    cycle_timer #(.W(CNT_W)) runTimer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr     (stateReg != RUN),
        .en      (!ProcAck),
        .limit   (TIMEOUT_VAL),
        .count   (runCount),
        .expired (runExpired)
    );

    cycle_timer #(.W(CNT_W)) startTimer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr     (stateReg != START),
        .en      (1'b1),
        .limit   (START_LAST),
        .count   (startCountUnused),
        .expired (startExpired)
    );

    always_comb begin
        stateNext   = stateReg;
        progSelNext = ProgSel;
        case (stateReg)
            IDLE: begin
                if (Go) begin
                    stateNext   = START;
                    progSelNext = '0;
                end
            end
            START: begin
                if (startExpired) stateNext = RUN;
            end
            RUN: begin
                if (ProcAck || runExpired) stateNext = REPORT;
            end
            REPORT: begin
                if (ProgSel == LAST_SEL) begin
                    stateNext = DONE;
                end else begin
                    stateNext   = START;
                    progSelNext = ProgSel + SEL_W'(1);
                end
            end
            DONE: begin
                stateNext   = IDLE;
                progSelNext = '0;
            end
            default: stateNext = IDLE;
        endcase
        if (Abort) begin
            stateNext   = IDLE;
            progSelNext = '0;
        end
    end

    // Outputs are registered decodes of the next state, so they line up with it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateReg    <= IDLE;
            ProcStart   <= 1'b0;
            ProgSel     <= '0;
            Busy        <= 1'b0;
            ResultValid <= 1'b0;
            ResultIdx   <= '0;
            CycleCount  <= '0;
            TimedOut    <= 1'b0;
            BatchDone   <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            ProcStart   <= (stateNext == START);
            Busy        <= (stateNext != IDLE);
            ResultValid <= (stateNext == REPORT);
            BatchDone   <= (stateNext == DONE);
            ProgSel     <= progSelNext;
            if (stateReg == RUN && stateNext == REPORT) begin
                ResultIdx  <= ProgSel;
                CycleCount <= ProcAck ? runCount : TIMEOUT_VAL;
                TimedOut   <= !ProcAck;
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer: a reactive processor model acks after a
// chosen delay, and a scoreboard checks every reported result record.
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    localparam int NP    = 3;
    localparam int CW    = 16;
    localparam int SC    = 2;
    localparam int TO    = 300;
    localparam int SW    = idxWidth(NP);
    localparam int NEVER = 100000;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Go = 1'b0;
    logic          Abort = 1'b0;
    logic          ProcAck;
    logic          ProcStart;
    logic [SW-1:0] ProgSel;
    logic          Busy;
    logic          ResultValid;
    logic [SW-1:0] ResultIdx;
    logic [CW-1:0] CycleCount;
    logic          TimedOut;
    logic          BatchDone;

    prog_sequencer #(
        .NUM_PROGS   (NP),
        .CNT_W       (CW),
        .START_CYC   (SC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Go          (Go),
        .Abort       (Abort),
        .ProcAck     (ProcAck),
        .ProcStart   (ProcStart),
        .ProgSel     (ProgSel),
        .Busy        (Busy),
        .ResultValid (ResultValid),
        .ResultIdx   (ResultIdx),
        .CycleCount  (CycleCount),
        .TimedOut    (TimedOut),
        .BatchDone   (BatchDone)
    );

    always #5 Clk = ~Clk;

    int      total = 0;
    int      bad = 0;
    int      doneCount = 0;
    int      doneExp = 0;
    result_t expQ[$];
    int      delayQ[$];
    int      idxQ[$];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference rule: ack after d idle RUN cycles reports d, capped at the timeout.
    function automatic result_t expOf(input int idx, input int d);
        result_t r;
        r.idx      = IDX_W_DEF'(idx);
        r.count    = CNT_W_DEF'((d <= TO) ? d : TO);
        r.timedOut = (d > TO);
        return r;
    endfunction

    function automatic int pickDelay();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return TO;
            1:       return TO - 1;
            2:       return TO + 1;
            3:       return NEVER;
            default: return int'($urandom_range(0, 40));
        endcase
    endfunction

    task automatic queueBatch(input int d0, input int d1, input int d2, input int nExp);
        int d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < NP; i++) begin
            delayQ.push_back(d[i]);
            idxQ.push_back(i);
            if (i < nExp) expQ.push_back(expOf(i, d[i]));
        end
        $display("batch delays=%0d,%0d,%0d expected_results=%0d", d0, d1, d2, nExp);
    endtask

    task automatic pulseGo();
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
    endtask

    // mode 0: quiet, 1: random Go noise, 2: Go held high for the whole batch
    task automatic runBatch(input int d0, input int d1, input int d2, input int mode);
        bit seen;
        queueBatch(d0, d1, d2, NP);
        doneExp++;
        pulseGo();
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (mode == 1) Go = ($urandom_range(0, 2) == 0);
            if (mode == 2) Go = 1'b1;
            @(negedge Clk);
            if (BatchDone) seen = 1'b1;
        end
        Go = 1'b0;
        check("batch_finished", longint'(seen), 1);
        check("queue_drained", longint'(expQ.size()), 0);
        @(negedge Clk);
    endtask

    task automatic waitRun(input int idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge Clk);
            if (Busy && !ProcStart && !ResultValid && !BatchDone && int'(ProgSel) == idx) ok = 1'b1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_procstart"}, longint'(ProcStart), 0);
        check({tag, "_busy"}, longint'(Busy), 0);
        check({tag, "_resultvalid"}, longint'(ResultValid), 0);
        check({tag, "_batchdone"}, longint'(BatchDone), 0);
        check({tag, "_timedout"}, longint'(TimedOut), 0);
        check({tag, "_progsel"}, longint'(ProgSel), 0);
        check({tag, "_resultidx"}, longint'(ResultIdx), 0);
        check({tag, "_cyclecount"}, longint'(CycleCount), 0);
    endtask

    // Processor model: acks d cycles into RUN and keeps Ack high until the next run.
    initial begin : procModel
        bit prevStart;
        bit inRun;
        int runCyc;
        int curDelay;
        int startLen;
        prevStart = 1'b0; inRun = 1'b0; runCyc = 0; curDelay = NEVER; startLen = 0;
        ProcAck = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                prevStart = 1'b0; inRun = 1'b0; runCyc = 0; curDelay = NEVER; startLen = 0;
                ProcAck = 1'b0;
            end else begin
                if (ProcStart && !prevStart) begin
                    startLen = 0;
                    if (delayQ.size() > 0) begin
                        curDelay = delayQ.pop_front();
                        check("prog_sel", longint'(ProgSel), longint'(idxQ.pop_front()));
                    end else begin
                        curDelay = NEVER;
                        check("unexpected_start", longint'(ProcStart), 0);
                    end
                end
                if (ProcStart) startLen++;
                if (!ProcStart && prevStart && Busy) begin
                    check("start_len", longint'(startLen), SC);
                    inRun = 1'b1;
                    runCyc = 1;
                end else if (inRun) begin
                    runCyc++;
                end
                if (!Busy || ProcStart) inRun = 1'b0;
                if (inRun) ProcAck = (runCyc > curDelay);
                prevStart = ProcStart;
            end
        end
    end

    // Scoreboard monitor: pops one expected record per ResultValid pulse.
    initial begin : monitor
        bit doneDue;
        bit prevDone;
        result_t e;
        doneDue = 1'b0; prevDone = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                doneDue = 1'b0; prevDone = 1'b0;
            end else begin
                if (prevDone) check("busy_after_done", longint'(Busy), 0);
                if (BatchDone || doneDue) check("batch_done", longint'(BatchDone), longint'(doneDue));
                if (BatchDone) doneCount++;
                prevDone = BatchDone;
                doneDue = 1'b0;
                if (ResultValid) begin
                    $display("result idx=%0d count=%0d timedOut=%0d", ResultIdx, CycleCount, TimedOut);
                    if (expQ.size() == 0) begin
                        check("spurious_result", longint'(ResultValid), 0);
                    end else begin
                        e = expQ.pop_front();
                        check("result_idx", longint'(ResultIdx), longint'(e.idx));
                        check("cycle_count", longint'(CycleCount), longint'(e.count));
                        check("timed_out", longint'(TimedOut), longint'(e.timedOut));
                        doneDue = (int'(e.idx) == NP - 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: actual=hang required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        #2 Reset = 1'b0;
        #2 checkAllZero("reset");
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // Ack delays 10, 0, 255 with stale Ack held through each START.
        runBatch(10, 0, 255, 0);
        // Timeouts, ack exactly at the timeout, and Go noise during the batch.
        runBatch(7, TO, NEVER, 1);
        runBatch(TO - 1, 3, TO + 1, 2);

        // Abort during the second program's RUN.
        queueBatch(12, 60, 5, 1);
        pulseGo();
        waitRun(1, ok);
        check("abort_reached_run", longint'(ok), 1);
        repeat (5) @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("abort_procstart", longint'(ProcStart), 0);
        check("abort_progsel", longint'(ProgSel), 0);
        check("abort_busy", longint'(Busy), 0);
        check("abort_cyclecount", longint'(CycleCount), 12);
        check("abort_timedout", longint'(TimedOut), 0);
        delayQ.delete(); idxQ.delete();
        repeat (30) @(negedge Clk);
        check("abort_idle", longint'(Busy), 0);
        check("abort_queue", longint'(expQ.size()), 0);

        // Abort and Go together in IDLE keep the sequencer idle.
        @(negedge Clk); Go = 1'b1; Abort = 1'b1;
        @(negedge Clk); Go = 1'b0; Abort = 1'b0;
        check("abort_go_busy", longint'(Busy), 0);
        check("abort_go_procstart", longint'(ProcStart), 0);

        // Reset mid-RUN of program 1 with its counter at 37.
        queueBatch(TO + 5, 100, 5, 1);
        pulseGo();
        waitRun(1, ok);
        check("reset_reached_run", longint'(ok), 1);
        repeat (37) @(negedge Clk);
        check("pre_reset_timedout", longint'(TimedOut), 1);
        #1 Reset = 1'b0;
        #1 checkAllZero("midrun_reset");
        expQ.delete(); delayQ.delete(); idxQ.delete();
        @(negedge Clk);
        #2 Reset = 1'b1;
        repeat (20) @(negedge Clk);
        check("post_reset_idle", longint'(Busy), 0);

        for (int b = 0; b < 6; b++) begin
            runBatch(pickDelay(), pickDelay(), pickDelay(), int'($urandom_range(0, 2)));
        end
        runBatch(1, 2, 3, 0);

        check("batch_count", longint'(doneCount), longint'(doneExp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
